// File: rtl/vector_multi_lane_unit.sv
// Multi-lane vector ALU: elementwise or reduction ops over a VLEN-bit register,
// LANE_SIZE elements per WORKING cycle, tail/inactive elements left undisturbed.
`ifndef VEC_ALU_NOP
`define VEC_ALU_NOP      2'd0
`define VEC_ALU_WORKING  2'd1
`define VEC_ALU_FINISHED 2'd2
`endif
`ifndef ONE_BYTE
`define ONE_BYTE   3'd0
`define TWO_BYTE   3'd1
`define FOUR_BYTE  3'd2
`define EIGHT_BYTE 3'd3
`endif

module vector_multi_lane_unit #(
   parameter int LANE_SIZE      = 4,
   parameter int VLEN           = 256,
   parameter int SCALAR_REG_LEN = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy_in,
   input  logic                      execute,
   input  logic [2:0]                vsew,
   input  logic                      vm,
   input  logic [31:0]               length,
   input  logic [VLEN-1:0]           vs1,
   input  logic [VLEN-1:0]           vs2,
   input  logic [VLEN-1:0]           vd_old,
   input  logic [VLEN-1:0]           mask,
   input  logic [SCALAR_REG_LEN-1:0] rs,
   input  logic [3:0]                opcode,
   input  logic                      use_scalar,
   input  logic                      reduction,
   output logic [VLEN-1:0]           result,
   output logic [1:0]                status,
   output logic                      illegal
);

   // Handshake: an operation is accepted on a rising edge where status is NOP,
   // execute=1 and rdy_in=1; rdy_in=0 freezes every register, rst overrides all.

   localparam logic [31:0] LANE_W  = 32'(LANE_SIZE);
   localparam logic [3:0]  OP_ADD  = 4'd0;
   localparam logic [3:0]  OP_SUB  = 4'd1;
   localparam logic [3:0]  OP_AND  = 4'd2;
   localparam logic [3:0]  OP_OR   = 4'd3;
   localparam logic [3:0]  OP_XOR  = 4'd4;
   localparam logic [3:0]  OP_MINU = 4'd5;
   localparam logic [3:0]  OP_MAXU = 4'd6;

   typedef enum logic [1:0] {
      ST_NOP      = `VEC_ALU_NOP,
      ST_WORKING  = `VEC_ALU_WORKING,
      ST_FINISHED = `VEC_ALU_FINISHED
   } state_t;

   state_t            state;
   logic [VLEN-1:0]   result_r;
   logic              illegal_r;
   logic [31:0]       next_r;
   logic [63:0]       acc_r;
   logic [VLEN-1:0]   vs1_r;
   logic [VLEN-1:0]   vs2_r;
   logic [VLEN-1:0]   mask_r;
   logic [63:0]       scalar_r;
   logic [2:0]        sew_r;
   logic              vm_r;
   logic [3:0]        op_r;
   logic              use_scalar_r;
   logic              red_r;
   logic [31:0]       eff_len_r;

   function automatic logic [2:0] sew_log(input logic [2:0] s);
      case (s)
         `ONE_BYTE:  return 3'd3;
         `TWO_BYTE:  return 3'd4;
         `FOUR_BYTE: return 3'd5;
         default:    return 3'd6;
      endcase
   endfunction

   function automatic logic [63:0] sew_mask(input logic [2:0] s);
      case (s)
         `ONE_BYTE:  return 64'h0000_0000_0000_00FF;
         `TWO_BYTE:  return 64'h0000_0000_0000_FFFF;
         `FOUR_BYTE: return 64'h0000_0000_FFFF_FFFF;
         default:    return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

   function automatic logic [63:0] get_elem(input logic [VLEN-1:0] v, input logic [31:0] sh,
                                            input logic [63:0] m);
      return 64'(v >> sh) & m;
   endfunction

   function automatic logic [VLEN-1:0] put_elem(input logic [VLEN-1:0] v, input logic [31:0] sh,
                                                input logic [63:0] val, input logic [63:0] m);
      logic [VLEN-1:0] mw;
      mw = VLEN'(m) << sh;
      return (v & ~mw) | (VLEN'(val & m) << sh);
   endfunction

   function automatic logic mask_bit(input logic [VLEN-1:0] m, input logic [31:0] idx);
      return 1'(m >> idx);
   endfunction

   // x2 plays the vs2 role so SUB yields vs2 - vs1; result wraps to SEW.
   function automatic logic [63:0] alu(input logic [3:0] op, input logic [63:0] x2,
                                       input logic [63:0] x1, input logic [63:0] m);
      logic [63:0] r;
      case (op)
         OP_ADD:  r = x2 + x1;
         OP_SUB:  r = x2 - x1;
         OP_AND:  r = x2 & x1;
         OP_OR:   r = x2 | x1;
         OP_XOR:  r = x2 ^ x1;
         OP_MINU: r = (x2 < x1) ? x2 : x1;
         OP_MAXU: r = (x2 > x1) ? x2 : x1;
         default: r = x2;
      endcase
      return r & m;
   endfunction

   // Accept-time decode, taken straight from the inputs.
   logic [63:0] in_smask;
   logic [31:0] in_vlmax;
   logic [31:0] in_eff_len;
   logic        in_illegal;
   logic [63:0] rs64;
   logic [63:0] in_acc0;

   assign rs64       = 64'(rs);
   assign in_smask   = sew_mask(vsew);
   assign in_vlmax   = 32'(VLEN) >> sew_log(vsew);
   assign in_eff_len = (length < in_vlmax) ? length : in_vlmax;
   assign in_illegal = (opcode > OP_MAXU) || ((opcode == OP_SUB) && reduction);
   assign in_acc0    = use_scalar ? (rs64 & in_smask) : (vs1[63:0] & in_smask);

   // One WORKING step: lanes are chained so a reduction folds in ascending order.
   logic [63:0]     smask;
   logic [VLEN-1:0] res_nxt;
   logic [63:0]     acc_nxt;
   logic [31:0]     idx;
   logic [31:0]     sh;
   logic [63:0]     e1;
   logic [63:0]     e2;
   logic            active;

   assign smask = sew_mask(sew_r);

   always_comb begin
      res_nxt = result_r;
      acc_nxt = acc_r;
      idx     = '0;
      sh      = '0;
      e1      = '0;
      e2      = '0;
      active  = 1'b0;
      for (int l = 0; l < LANE_SIZE; l++) begin
         idx    = next_r + 32'(l);
         sh     = idx << sew_log(sew_r);
         active = (idx < eff_len_r) && (vm_r || mask_bit(mask_r, idx));
         e1     = use_scalar_r ? scalar_r : get_elem(vs1_r, sh, smask);
         e2     = get_elem(vs2_r, sh, smask);
         if (active) begin
            if (red_r) acc_nxt = alu(op_r, e2, acc_nxt, smask);
            else       res_nxt = put_elem(res_nxt, sh, alu(op_r, e2, e1, smask), smask);
         end
      end
      if (red_r) res_nxt = put_elem(res_nxt, 32'd0, acc_nxt, smask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_NOP;
         result_r     <= '0;
         illegal_r    <= 1'b0;
         next_r       <= '0;
         acc_r        <= '0;
         vs1_r        <= '0;
         vs2_r        <= '0;
         mask_r       <= '0;
         scalar_r     <= '0;
         sew_r        <= '0;
         vm_r         <= 1'b0;
         op_r         <= '0;
         use_scalar_r <= 1'b0;
         red_r        <= 1'b0;
         eff_len_r    <= '0;
      end else if (rdy_in) begin
         case (state)
            ST_NOP: begin
               if (execute) begin
                  vs1_r        <= vs1;
                  vs2_r        <= vs2;
                  mask_r       <= mask;
                  scalar_r     <= rs64 & in_smask;
                  sew_r        <= vsew;
                  vm_r         <= vm;
                  op_r         <= opcode;
                  use_scalar_r <= use_scalar;
                  red_r        <= reduction;
                  eff_len_r    <= in_eff_len;
                  result_r     <= vd_old;
                  illegal_r    <= in_illegal;
                  next_r       <= '0;
                  acc_r        <= in_acc0;
                  state        <= (in_illegal || (in_eff_len == 32'd0)) ? ST_FINISHED : ST_WORKING;
               end
            end
            ST_WORKING: begin
               result_r <= res_nxt;
               acc_r    <= acc_nxt;
               next_r   <= next_r + LANE_W;
               if (next_r + LANE_W >= eff_len_r) state <= ST_FINISHED;
            end
            ST_FINISHED: begin
               illegal_r <= 1'b0;
               state     <= ST_NOP;
            end
            default: state <= ST_NOP;
         endcase
      end
   end

   assign result  = result_r;
   assign status  = state;
   assign illegal = illegal_r;

endmodule
